// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector on RGB565 video with sync signals delayed to match.
// Define SOBEL_OVERLAY_EN to draw edges in OVERLAY_COLOR over the delayed camera image.
module sobel_edge_filter #(
    parameter int H_ACTIVE_MAX = 1024
`ifdef SOBEL_OVERLAY_EN
    ,
    parameter logic [15:0] OVERLAY_COLOR = 16'h07E0
`endif
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [7:0]  threshold,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [15:0] i_data,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [15:0] o_data
);
    localparam int LATENCY = 5;
    localparam int AW      = $clog2(H_ACTIVE_MAX);

    logic        vs_prev, de_prev, frame_ok;
    logic [11:0] x_cnt, y_cnt;
    logic [7:0]  thr_r;
    logic        frame_start, de_fall, pos_ok;

    logic [7:0]  r8, g8, b8, gray_c;
    logic [15:0] y_sum;

    logic [7:0]    gray1, gray2, rd0, rd1;
    logic [AW-1:0] addr1;
    logic          we1, de1, de2, de3, de4, ok1, ok2, ok3, ok4;
    logic [7:0]    lb0 [0:H_ACTIVE_MAX-1];
    logic [7:0]    lb1 [0:H_ACTIVE_MAX-1];
    logic [7:0]    win [0:2][0:2];

    logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_c, gy_c, gx4, gy4;
    logic [10:0]        ax, ay;
    logic [11:0]        mag_sum;
    logic [7:0]         mag8;
    logic               edge_hit;
    logic [15:0]        px_out;

    logic [LATENCY-2:0] hs_dl, vs_dl;
`ifdef SOBEL_OVERLAY_EN
    logic [15:0] d_dl [0:LATENCY-2];
`endif

    assign frame_start = vs_prev & ~i_vs;
    assign de_fall     = de_prev & ~i_de;
    assign pos_ok      = (x_cnt >= 12'd2) && (y_cnt >= 12'd2) && (x_cnt < 12'(H_ACTIVE_MAX));

    assign r8     = {i_data[15:11], i_data[15:13]};
    assign g8     = {i_data[10:5],  i_data[10:9]};
    assign b8     = {i_data[4:0],   i_data[4:2]};
    assign y_sum  = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    assign gray_c = 8'(y_sum >> 8);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev  <= 1'b0;
            de_prev  <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            thr_r    <= '0;
            frame_ok <= 1'b0;
        end else begin
            vs_prev <= i_vs;
            de_prev <= i_de;
            if (!i_de)
                x_cnt <= '0;
            else if (x_cnt != 12'hFFF)
                x_cnt <= x_cnt + 12'd1;
            if (frame_start) begin
                y_cnt    <= '0;
                thr_r    <= threshold;
                frame_ok <= 1'b1;
            end else if (de_fall && y_cnt != 12'hFFF) begin
                y_cnt <= y_cnt + 12'd1;
            end
        end
    end

    // Line buffers hold no reset; lb1 takes the row that lb0 is about to overwrite.
    always_ff @(posedge pclk) begin
        rd0 <= lb0[addr1];
        rd1 <= lb1[addr1];
        if (we1) begin
            lb0[addr1] <= gray1;
            lb1[addr1] <= lb0[addr1];
        end
    end

    always_comb begin
        gx_pos = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
        gx_neg = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
        gy_pos = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
        gy_neg = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
        gx_c   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_c   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end

    always_comb begin
        ax       = gx4[10] ? 11'(-gx4) : 11'(gx4);
        ay       = gy4[10] ? 11'(-gy4) : 11'(gy4);
        mag_sum  = {1'b0, ax} + {1'b0, ay};
        mag8     = (mag_sum > 12'd255) ? 8'hFF : mag_sum[7:0];
        edge_hit = (mag8 > thr_r) && frame_ok && ok4;
`ifdef SOBEL_OVERLAY_EN
        px_out   = edge_hit ? OVERLAY_COLOR : d_dl[LATENCY-2];
`else
        px_out   = edge_hit ? 16'hFFFF : 16'h0000;
`endif
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            gray1 <= '0; addr1 <= '0; we1 <= 1'b0; de1 <= 1'b0; ok1 <= 1'b0;
            gray2 <= '0; de2 <= 1'b0; ok2 <= 1'b0;
            de3   <= 1'b0; ok3 <= 1'b0;
            gx4   <= '0; gy4 <= '0; de4 <= 1'b0; ok4 <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            hs_dl  <= '0;
            vs_dl  <= '0;
            o_hs   <= 1'b0;
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= 16'h0000;
        end else begin
            gray1 <= gray_c;
            addr1 <= x_cnt[AW-1:0];
            we1   <= i_de && (x_cnt < 12'(H_ACTIVE_MAX));
            de1   <= i_de;
            ok1   <= i_de && pos_ok;

            gray2 <= gray1;
            de2   <= de1;
            ok2   <= ok1;

            // Column 2 is the newest pixel; row 0 is two lines up.
            if (de2) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= rd1;
                win[1][2] <= rd0;
                win[2][2] <= gray2;
            end
            de3 <= de2;
            ok3 <= ok2;

            gx4 <= gx_c;
            gy4 <= gy_c;
            de4 <= de3;
            ok4 <= ok3;

            hs_dl  <= {hs_dl[LATENCY-3:0], i_hs};
            vs_dl  <= {vs_dl[LATENCY-3:0], i_vs};
            o_hs   <= hs_dl[LATENCY-2];
            o_vs   <= vs_dl[LATENCY-2];
            o_de   <= de4;
            o_data <= de4 ? px_out : 16'h0000;
        end
    end

`ifdef SOBEL_OVERLAY_EN
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY - 1; i++)
                d_dl[i] <= '0;
        end else begin
            d_dl[0] <= i_data;
            for (int i = 1; i < LATENCY - 1; i++)
                d_dl[i] <= d_dl[i-1];
        end
    end
`endif

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Scoreboard bench for sobel_edge_filter: directed frames, image-level Sobel reference model.
module tb_sobel_edge_filter;
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
    logic [15:0] i_data = 16'h0000;
    logic        o_hs, o_vs, o_de;
    logic [15:0] o_data;

`ifdef SOBEL_OVERLAY_EN
    localparam logic [15:0] EDGE_C = 16'h07E0;
`else
    localparam logic [15:0] EDGE_C = 16'hFFFF;
`endif

    sobel_edge_filter dut (
        .pclk(pclk), .rst_n(rst_n), .threshold(threshold),
        .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data)
    );

    always #5 pclk = ~pclk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          edge_cnt = 0;
    logic [15:0] exp_q [$];
    bit          m_fok = 1'b0;
    logic [7:0]  m_thr = 8'd0;
    logic [2:0]  hist [0:4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [15:0] pix(int pat, int w, int x, int y);
        int unsigned h;
        case (pat)
            0: return 16'hFFFF;
            1: return (x < w / 2) ? 16'h0000 : 16'hFFFF;
            3: return (x < w / 2) ? 16'h0000 : (x < 3 * w / 4) ? 16'h2104 : 16'hFFFF;
            default: begin
                h = unsigned'(x) * 32'd1103515245 + unsigned'(y) * 32'd12345 + 32'd777;
                h = h ^ (h >> 13);
                h = h * 32'h9E3779B1;
                return h[31:16];
            end
        endcase
    endfunction

    function automatic int gray8(logic [15:0] d);
        int r, g, b;
        r = int'({d[15:11], d[15:13]});
        g = int'({d[10:5], d[10:9]});
        b = int'({d[4:0], d[4:2]});
        return (77 * r + 150 * g + 29 * b) >> 8;
    endfunction

    function automatic int mag_at(int pat, int w, int cx, int cy);
        int g [0:2][0:2];
        int gx, gy, m;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                g[r][c] = gray8(pix(pat, w, cx - 1 + c, cy - 1 + r));
        gx = (g[0][2] + 2 * g[1][2] + g[2][2]) - (g[0][0] + 2 * g[1][0] + g[2][0]);
        gy = (g[2][0] + 2 * g[2][1] + g[2][2]) - (g[0][0] + 2 * g[0][1] + g[0][2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    function automatic logic [15:0] exp_px(int pat, int w, int x, int y);
        bit e;
        e = m_fok && x >= 2 && y >= 2 && x < 1024 && (mag_at(pat, w, x - 1, y - 1) > int'(m_thr));
`ifdef SOBEL_OVERLAY_EN
        return e ? EDGE_C : pix(pat, w, x, y);
`else
        return e ? EDGE_C : 16'h0000;
`endif
    endfunction

    // Inputs as sampled at each rising edge; entry 4 is what o_* must show now.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) hist[i] <= 3'b000;
        end else begin
            hist[0] <= {i_hs, i_vs, i_de};
            for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
        end
    end

    always @(negedge pclk) begin
        if (rst_n) begin
            chk("sync_delay", {29'd0, o_hs, o_vs, o_de}, {29'd0, hist[4]});
            if (o_de) begin
                chk("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    chk("pixel_data", {16'd0, o_data}, {16'd0, exp_q.pop_front()});
                if (o_data == EDGE_C) edge_cnt++;
            end else begin
                chk("blank_data_zero", {16'd0, o_data}, 32'd0);
            end
        end
    end

    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic [15:0] d, input logic [15:0] e);
        i_hs = hs; i_vs = vs; i_de = de; i_data = d;
        if (de) exp_q.push_back(e);
        @(posedge pclk);
        #1;
    endtask

    task automatic run_frame(input int w, input int h, input int pat, input bit do_vs,
                             input int chg_line, input logic [7:0] new_thr, input int stop_after);
        int n = 0;
        if (do_vs) begin
            repeat (3) drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
            m_fok = 1'b1;
            m_thr = threshold;
        end
        for (int l = 0; l < h; l++) begin
            for (int b = 0; b < 4; b++) drive(b < 2, 1'b0, 1'b0, 16'h0, 16'h0);
            if (l == chg_line) threshold = new_thr;
            for (int x = 0; x < w; x++) begin
                if (n == stop_after) return;
                drive(1'b0, 1'b0, 1'b1, pix(pat, w, x, l), exp_px(pat, w, x, l));
                n++;
            end
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_o_hs"},   {31'd0, o_hs},   32'd0);
        chk({tag, "_o_vs"},   {31'd0, o_vs},   32'd0);
        chk({tag, "_o_de"},   {31'd0, o_de},   32'd0);
        chk({tag, "_o_data"}, {16'd0, o_data}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Mid-line reset, then a frame that never sees a vsync falling edge.
        threshold = 8'd100;
        run_frame(32, 4, 1, 1'b1, -1, 8'd0, 40);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midline_reset");
        m_fok = 1'b0;
        exp_q.delete();
        i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_data = 16'h0;
        repeat (2) @(posedge pclk);
        #1 rst_n = 1'b1;
        edge_cnt = 0;
        run_frame(32, 5, 1, 1'b0, -1, 8'd0, -1);
        chk("no_frame_start_edges", 32'(edge_cnt), 32'd0);

        threshold = 8'd8;
        edge_cnt = 0;
        run_frame(32, 6, 0, 1'b1, -1, 8'd0, -1);
        chk("flat_frame_edges", 32'(edge_cnt), 32'd0);

        // Step at x=16: edges only at x=16,17 on rows 2..5.
        threshold = 8'd100;
        edge_cnt = 0;
        run_frame(32, 6, 1, 1'b1, -1, 8'd0, -1);
        chk("vertical_step_edges", 32'(edge_cnt), 32'd8);

        threshold = 8'd60;
        run_frame(24, 6, 2, 1'b1, -1, 8'd0, -1);

        // mag 128 steps at x=16,17 and saturated steps at x=24,25; threshold moves to 254 on line 2.
        threshold = 8'd100;
        edge_cnt = 0;
        run_frame(32, 5, 3, 1'b1, 2, 8'd254, -1);
        chk("thr_old_frame_edges", 32'(edge_cnt), 32'd12);
        edge_cnt = 0;
        run_frame(32, 5, 3, 1'b1, -1, 8'd0, -1);
        chk("thr_new_frame_edges", 32'(edge_cnt), 32'd6);

        threshold = 8'd60;
        run_frame(1100, 4, 2, 1'b1, -1, 8'd0, -1);

        repeat (8) @(posedge pclk);
        #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
